// File: rtl/anomaly_response_ctrl.sv
// -----------------------------------------------------------------------------
// anomaly_response_ctrl
//
// Supervisory controller that sits behind the 8-way anomaly detector.
//   * Owns the live detector configuration (spike/flash thresholds, alert mask).
//   * Sequences the market-protection response NORMAL -> WARN -> HALT ->
//     COOLDOWN -> NORMAL.
//   * Keeps sticky alert flags, a saturating alert-event counter and a
//     one-cycle halt interrupt for the host/UI.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous active-high reset
//   alert_bitmap   in   8   detector flags, bit7 = flash crash, bit0 = spike
//   halt_clear     in   1   operator acknowledge, requests exit from HALT
//   cfg_wr_en      in   1   config write strobe
//   cfg_addr       in   2   0 spike_thresh, 1 flash_thresh, 2 alert_mask,
//                           3 alert_latched (write-1-to-clear)
//   cfg_wdata      in  12   config write data
//   cfg_rdata      out 12   combinational readback of cfg_addr
//   spike_thresh   out 12   threshold to detector
//   flash_thresh   out 12   threshold to detector
//   halt_trading   out  1   high in HALT
//   throttle       out  1   high in WARN or COOLDOWN
//   ctrl_state     out  2   0 NORMAL, 1 WARN, 2 HALT, 3 COOLDOWN
//   alert_latched  out  8   sticky masked alert flags
//   alert_count    out  8   saturating count of masked-alert rising edges
//   irq            out  1   one-cycle pulse on every HALT entry
// -----------------------------------------------------------------------------
module anomaly_response_ctrl #(
  parameter int PERSIST_CYCLES  = 4,   // 1..15
  parameter int COOLDOWN_CYCLES = 64,  // 1..255
  parameter int WARN_PRI        = 4    // 0..6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alert_bitmap,
  input  logic        halt_clear,
  input  logic        cfg_wr_en,
  input  logic [1:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  output logic [11:0] cfg_rdata,
  output logic [11:0] spike_thresh,
  output logic [11:0] flash_thresh,
  output logic        halt_trading,
  output logic        throttle,
  output logic [1:0]  ctrl_state,
  output logic [7:0]  alert_latched,
  output logic [7:0]  alert_count,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARN     = 2'd1,
    ST_HALT     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] PERSIST_LAST = 4'(PERSIST_CYCLES - 1);
  localparam logic [7:0] COOL_LOAD    = 8'(COOLDOWN_CYCLES);
  // Bits at or above WARN_PRI qualify as warnings.
  localparam logic [7:0] PRI_MASK     = 8'hFF << WARN_PRI;

  // Registers
  state_t      r_state;
  logic [3:0]  r_persist;
  logic [7:0]  r_cool;
  logic        r_irq;
  logic [11:0] r_spike;
  logic [11:0] r_flash;
  logic [7:0]  r_mask;
  logic [7:0]  r_latched;
  logic [7:0]  r_count;
  logic        r_prev_any;

  // Derived alert qualifiers
  logic [7:0] w_masked;
  logic       w_flash;
  logic       w_qual;
  logic       w_any;
  logic       w_cfg_lock;
  logic [7:0] w_w1c;

  assign w_masked   = alert_bitmap & r_mask;
  assign w_flash    = w_masked[7];
  assign w_qual     = |(w_masked & PRI_MASK);
  assign w_any      = |w_masked;
  assign w_cfg_lock = (r_state == ST_HALT);
  assign w_w1c      = (cfg_wr_en && cfg_addr == 2'd3) ? cfg_wdata[7:0] : 8'h00;

  // ---------------------------------------------------------------------------
  // Response FSM. irq is raised on every transition into HALT so it is high
  // for exactly the first cycle the state register reads HALT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_NORMAL;
      r_persist <= 4'd0;
      r_cool    <= 8'd0;
      r_irq     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the default below is overridden on HALT entry.
      r_irq <= 1'b0;
      unique case (r_state)
        ST_NORMAL: begin
          if (w_flash) begin
            r_state <= ST_HALT;
            r_irq   <= 1'b1;
          end else if (w_qual) begin
            r_state   <= ST_WARN;
            r_persist <= 4'd1;
          end
        end
        ST_WARN: begin
          // ">=" lets PERSIST_CYCLES = 1 halt on the second qualifying cycle.
          if (w_flash || (w_qual && r_persist >= PERSIST_LAST)) begin
            r_state   <= ST_HALT;
            r_irq     <= 1'b1;
            r_persist <= 4'd0;
          end else if (w_qual) begin
            r_persist <= r_persist + 4'd1;
          end else begin
            r_state   <= ST_NORMAL;
            r_persist <= 4'd0;
          end
        end
        ST_HALT: begin
          // Acknowledge is ignored while the flash condition persists.
          if (halt_clear && !w_flash) begin
            r_state <= ST_COOLDOWN;
            r_cool  <= COOL_LOAD;
          end
        end
        ST_COOLDOWN: begin
          if (w_flash) begin
            r_state <= ST_HALT;
            r_irq   <= 1'b1;
          end else if (w_qual) begin
            r_cool <= COOL_LOAD;
          end else begin
            if (r_cool == 8'd1) r_state <= ST_NORMAL;
            r_cool <= r_cool - 8'd1;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers. Threshold/mask writes are locked while halted so
  // the operator cannot retune the detector before acknowledging the halt.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spike <= 12'd20;
      r_flash <= 12'd40;
      r_mask  <= 8'hFF;
    end else if (cfg_wr_en && !w_cfg_lock) begin
      unique case (cfg_addr)
        2'd0: r_spike <= cfg_wdata;
        // A zero flash threshold would fire continuously; clamp it to 1.
        2'd1: r_flash <= (cfg_wdata == 12'd0) ? 12'd1 : cfg_wdata;
        2'd2: r_mask  <= cfg_wdata[7:0];
        default: ;  // addr 3 is the W1C path handled with the flags
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags and event counter. A new masked alert wins over a same-cycle
  // W1C so an event is never lost. The counter counts rising edges of "any
  // masked alert" and saturates.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latched  <= 8'h00;
      r_count    <= 8'd0;
      r_prev_any <= 1'b0;
    end else begin
      r_latched  <= (r_latched & ~w_w1c) | w_masked;
      r_prev_any <= w_any;
      if (w_any && !r_prev_any && r_count != 8'hFF) r_count <= r_count + 8'd1;
    end
  end

  // Readback mux
  always_comb begin
    // NOTE: default assignment first keeps this purely combinational (no latch).
    cfg_rdata = 12'd0;
    unique case (cfg_addr)
      2'd0: cfg_rdata = r_spike;
      2'd1: cfg_rdata = r_flash;
      2'd2: cfg_rdata = {4'd0, r_mask};
      2'd3: cfg_rdata = {4'd0, r_latched};
      default: cfg_rdata = 12'd0;
    endcase
  end

  // Outputs decoded from registers
  assign spike_thresh  = r_spike;
  assign flash_thresh  = r_flash;
  assign ctrl_state    = r_state;
  assign halt_trading  = (r_state == ST_HALT);
  assign throttle      = (r_state == ST_WARN) || (r_state == ST_COOLDOWN);
  assign alert_latched = r_latched;
  assign alert_count   = r_count;
  assign irq           = r_irq;

endmodule

// File: tb/tb_anomaly_response_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for anomaly_response_ctrl. A behavioural model written
// from the controller's rules (plain integers) predicts every output after
// each clock edge; directed steps are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_anomaly_response_ctrl;

  localparam int PERSIST  = 4;
  localparam int COOLDOWN = 64;
  localparam int WPRI     = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  alert_bitmap;
  logic        halt_clear;
  logic        cfg_wr_en;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_wdata;
  logic [11:0] cfg_rdata;
  logic [11:0] spike_thresh;
  logic [11:0] flash_thresh;
  logic        halt_trading;
  logic        throttle;
  logic [1:0]  ctrl_state;
  logic [7:0]  alert_latched;
  logic [7:0]  alert_count;
  logic        irq;

  anomaly_response_ctrl #(
    .PERSIST_CYCLES (PERSIST),
    .COOLDOWN_CYCLES(COOLDOWN),
    .WARN_PRI       (WPRI)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alert_bitmap (alert_bitmap),
    .halt_clear   (halt_clear),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .spike_thresh (spike_thresh),
    .flash_thresh (flash_thresh),
    .halt_trading (halt_trading),
    .throttle     (throttle),
    .ctrl_state   (ctrl_state),
    .alert_latched(alert_latched),
    .alert_count  (alert_count),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (0 NORMAL, 1 WARN, 2 HALT, 3 COOLDOWN)
  int md_state, md_persist, md_cool, md_irq;
  int md_spike, md_flash, md_mask, md_latched, md_count, md_prev;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    md_state = 0; md_persist = 0; md_cool = 0; md_irq = 0;
    md_spike = 20; md_flash = 40; md_mask = 'hFF;
    md_latched = 0; md_count = 0; md_prev = 0;
  endtask

  // One clock edge of the controller's rules, applied to pre-edge values.
  task automatic model_edge(input logic r, input logic [7:0] bm, input logic hc,
                            input logic wr, input logic [1:0] ad, input logic [11:0] wd);
    int m, ns, clr;
    bit flash, qual;
    if (r) begin
      model_reset();
      return;
    end
    m     = int'(bm) & md_mask;
    flash = (m & 'h80) != 0;
    qual  = (m >> WPRI) != 0;
    ns    = md_state;
    case (md_state)
      0: if (flash) ns = 2;
         else if (qual) begin ns = 1; md_persist = 1; end
      1: if (flash) ns = 2;
         else if (qual) begin
           if (md_persist >= PERSIST - 1) ns = 2; else md_persist++;
         end else begin ns = 0; md_persist = 0; end
      2: if (hc && !flash) begin ns = 3; md_cool = COOLDOWN; end
      default: if (flash) ns = 2;
               else if (qual) md_cool = COOLDOWN;
               else begin
                 if (md_cool == 1) ns = 0;
                 md_cool--;
               end
    endcase
    md_irq = (ns == 2 && md_state != 2) ? 1 : 0;
    clr = 0;
    if (wr) begin
      if (ad == 2'd3) clr = int'(wd[7:0]);
      else if (md_state != 2) begin
        if (ad == 2'd0) md_spike = int'(wd);
        else if (ad == 2'd1) md_flash = (wd == 0) ? 1 : int'(wd);
        else md_mask = int'(wd[7:0]);
      end
    end
    md_latched = ((md_latched & ~clr) | m) & 'hFF;
    if (m != 0 && md_prev == 0 && md_count < 255) md_count++;
    md_prev  = (m != 0) ? 1 : 0;
    md_state = ns;
  endtask

  function automatic int model_rdata(input logic [1:0] ad);
    case (ad)
      2'd0:    return md_spike;
      2'd1:    return md_flash;
      2'd2:    return md_mask;
      default: return md_latched;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ":state"},   32'(ctrl_state),    32'(md_state));
    check({tag, ":halt"},    32'(halt_trading),  32'(md_state == 2));
    check({tag, ":throttle"},32'(throttle),      32'(md_state == 1 || md_state == 3));
    check({tag, ":irq"},     32'(irq),           32'(md_irq));
    check({tag, ":spike"},   32'(spike_thresh),  32'(md_spike));
    check({tag, ":flash"},   32'(flash_thresh),  32'(md_flash));
    check({tag, ":latched"}, 32'(alert_latched), 32'(md_latched));
    check({tag, ":count"},   32'(alert_count),   32'(md_count));
  endtask

  // Drive one cycle: apply inputs, check combinational readback, clock,
  // advance the model and check every registered output #1 after the edge.
  task automatic tick(input string tag, input logic r, input logic [7:0] bm, input logic hc,
                      input logic wr, input logic [1:0] ad, input logic [11:0] wd);
    rst = r; alert_bitmap = bm; halt_clear = hc;
    cfg_wr_en = wr; cfg_addr = ad; cfg_wdata = wd;
    #1;
    if (!r) check({tag, ":rdata"}, 32'(cfg_rdata), 32'(model_rdata(ad)));
    @(posedge clk);
    model_edge(r, bm, hc, wr, ad, wd);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 12'd0);
  endtask

  initial begin
    rst = 1'b1; alert_bitmap = '0; halt_clear = 1'b0;
    cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();

    // 1. Reset values and a threshold write
    tick("reset", 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 12'd0);
    tick("reset", 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 12'd0);
    check("reset_spike_20", 32'(spike_thresh), 32'd20);
    check("reset_flash_40", 32'(flash_thresh), 32'd40);
    check("reset_state_0",  32'(ctrl_state),   32'd0);
    tick("rd_mask", 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 12'd0);
    tick("wr_spike", 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 12'd35);
    check("spike_35", 32'(spike_thresh), 32'd35);
    tick("rd_spike", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 12'd0);
    tick("wr_flash0", 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 12'd0);
    check("flash_zero_clamp", 32'(flash_thresh), 32'd1);
    tick("wr_flash40", 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 12'd40);

    // 2. Flash escalation from NORMAL
    tick("flash", 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 12'd0);
    check("flash_halt_state", 32'(ctrl_state), 32'd2);
    check("flash_irq_hi",     32'(irq),        32'd1);
    check("flash_latched",    32'(alert_latched), 32'h80);
    check("flash_count",      32'(alert_count),   32'd1);
    idle("halt_idle", 1);
    check("irq_one_cycle", 32'(irq), 32'd0);

    // 4. HALT lock and exit
    tick("halt_lock", 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 12'd99);
    check("halt_lock_flash", 32'(flash_thresh), 32'd40);
    tick("clr_flash", 1'b0, 8'h80, 1'b1, 1'b0, 2'd0, 12'd0);
    check("clr_ignored", 32'(ctrl_state), 32'd2);
    tick("clr", 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 12'd0);
    check("cooldown_entry", 32'(ctrl_state), 32'd3);
    idle("cool", COOLDOWN - 1);
    check("cool_63", 32'(ctrl_state), 32'd3);
    idle("cool_end", 1);
    check("cool_done", 32'(throttle), 32'd0);

    // 3. WARN persistence
    for (int i = 0; i < 3; i++) tick("warn3", 1'b0, 8'h40, 1'b0, 1'b0, 2'd0, 12'd0);
    check("warn3_state", 32'(ctrl_state), 32'd1);
    idle("warn_drop", 1);
    check("warn_drop_normal", 32'(ctrl_state), 32'd0);
    for (int i = 0; i < 4; i++) tick("warn4", 1'b0, 8'h40, 1'b0, 1'b0, 2'd0, 12'd0);
    check("warn4_halt", 32'(ctrl_state), 32'd2);
    tick("clr2", 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 12'd0);
    idle("cool2", COOLDOWN);
    tick("bit0", 1'b0, 8'h01, 1'b0, 1'b0, 2'd3, 12'd0);
    check("bit0_normal", 32'(ctrl_state), 32'd0);

    // 5. COOLDOWN reload and re-halt
    tick("halt3", 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 12'd0);
    tick("clr3", 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 12'd0);
    idle("cool3", 29);
    tick("reload", 1'b0, 8'h20, 1'b0, 1'b0, 2'd0, 12'd0);
    idle("cool3b", COOLDOWN - 1);
    check("reload_still_cool", 32'(ctrl_state), 32'd3);
    idle("cool3c", 1);
    check("reload_normal", 32'(ctrl_state), 32'd0);
    tick("halt4", 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 12'd0);
    tick("clr4", 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 12'd0);
    idle("cool4", 10);
    tick("cool_flash", 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 12'd0);
    check("cool_flash_irq", 32'(irq), 32'd1);
    tick("clr5", 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 12'd0);
    idle("cool5", COOLDOWN);

    // 6. Mask and W1C
    tick("mask7f", 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 12'h07F);
    tick("w1c_all", 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 12'h0FF);
    tick("masked_flash", 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 12'd0);
    check("masked_no_halt", 32'(ctrl_state), 32'd0);
    check("masked_latch0",  32'(alert_latched), 32'd0);
    tick("w1c_vs_set", 1'b0, 8'h01, 1'b0, 1'b1, 2'd3, 12'h001);
    check("set_wins", 32'(alert_latched), 32'h01);
    for (int i = 0; i < 300; i++) begin
      tick("pulse_hi", 1'b0, 8'h01, 1'b0, 1'b0, 2'd3, 12'd0);
      tick("pulse_lo", 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 12'd0);
    end
    check("count_sat", 32'(alert_count), 32'd255);
    tick("mask_ff", 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 12'h0FF);

    // Reset while halted
    tick("halt6", 1'b0, 8'h80, 1'b0, 1'b0, 2'd0, 12'd0);
    tick("rst_in_halt", 1'b1, 8'h80, 1'b1, 1'b1, 2'd0, 12'd7);
    check("rst_in_halt_state", 32'(ctrl_state), 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [7:0]  bm;
      logic [11:0] wd;
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel < 8)       bm = 8'h00;
      else if (sel < 14) bm = 8'($urandom_range(1, 127));
      else               bm = 8'($urandom_range(0, 255));
      wd = 12'($urandom_range(0, 4095));
      tick("rand", ($urandom_range(0, 499) == 0), bm, ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
